shared_mem_arbiter: RTL and testbench
=====================================

Name: shared_mem_arbiter

Overview:
- Synthesizable single-bank shared memory with two access ports: CPU port and test/loader port.
- Replaces the ad-hoc behavioural memory around CPU_top. The test port preloads programs and reads results while the CPU runs.
- Generalised in data/address width, depth and read latency.
- Adds fixed-priority arbitration with an anti-starvation cap and per-port read-valid tracking.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 8, address width; memory depth = 2**ADDR_W words.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2; any other value is an elaboration error.
- MAX_STALL, 4, max consecutive CPU stall cycles before the CPU is granted (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request this cycle.
- cpu_we  in  1  CPU write enable (qualified by cpu_req).
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_stall  out  1  combinational; 1 = CPU request not granted this cycle, CPU must hold request.
- cpu_rdata  out  DATA_W  CPU read/write-echo data.
- cpu_rvalid  out  1  cpu_rdata valid pulse.
- tst_req  in  1  test port request.
- tst_we  in  1  test port write enable.
- tst_addr  in  ADDR_W  test address.
- tst_wdata  in  DATA_W  test write data.
- tst_ready  out  1  combinational; 1 = test request granted this cycle.
- tst_rdata  out  DATA_W  test read data.
- tst_rvalid  out  1  tst_rdata valid pulse.

Behaviour:
- Reset state:
  - cpu_rdata, tst_rdata = 0; cpu_rvalid, tst_rvalid = 0.
  - Stall counter = 0; all latency pipeline stages cleared.
  - Memory contents are NOT cleared by reset.
- Access rules:
  - One memory access per cycle, either read or write.
  - A granted write commits at the rising edge of the grant cycle.
- Arbitration, evaluated combinationally each cycle:
  - Only cpu_req: CPU granted; cpu_stall = 0, tst_ready = 0.
  - Only tst_req: test granted; tst_ready = 1.
  - Both asserted and stall_cnt < MAX_STALL: test granted; cpu_stall = 1, tst_ready = 1.
  - Both asserted and stall_cnt == MAX_STALL: CPU granted; cpu_stall = 0, tst_ready = 0.
  - Neither asserted: no access; cpu_stall = 0, tst_ready = 0.
- Stall counter (4 bits):
  - Increments on each cycle with cpu_req && cpu_stall.
  - Clears on any cycle the CPU is granted or cpu_req = 0.
  - Saturates at MAX_STALL.
- Handshake:
  - A requester holds req/we/addr/wdata stable until granted.
  - Changing the request while stalled is allowed; the request seen in the grant cycle is the one served.
- Read data:
  - A granted read at cycle T presents memory[addr] on the port's rdata with rvalid = 1 at cycle T+RD_LAT, for exactly one cycle.
  - RD_LAT=2 adds one output register stage; back-to-back reads are fully pipelined, one per cycle.
  - rdata holds its last value when rvalid = 0.
- Write echo:
  - A granted write at cycle T returns wdata on that port's rdata with rvalid = 1 at T+RD_LAT (write-first).
- Read-after-write:
  - A read at T+1 to an address written at T returns the new data, for either port.
- Valid tracking:
  - rvalid is tagged per port through the pipeline.
  - A grant that alternates ports never routes data to the wrong port.
- Address range: full range 0..2**ADDR_W-1 is legal; there is no wrap or decode beyond ADDR_W bits.
- Reset mid-operation:
  - In-flight reads are discarded; no rvalid is produced after reset release for pre-reset requests.
  - Writes granted before reset assertion persist.
- Unknown inputs: X on cpu_addr while cpu_req = 0 has no effect.

Test Plan:
- RD_LAT=1: tst writes 16'h0001 to addr 50, then CPU reads 50 -> cpu_rvalid one cycle later, cpu_rdata = 16'h0001, cpu_stall = 0 throughout.
- RD_LAT=2: CPU issues back-to-back reads to addrs 0,1,2 holding 16'h0232, 16'h0164, 16'h0333 -> three consecutive cpu_rvalid pulses starting T+2 with data in order.
- Collision, MAX_STALL=4: cpu_req and tst_req held high for 10 cycles -> cpu_stall = 1 for cycles 0-3, CPU granted at cycle 4, test regranted cycle 5; pattern repeats; no data crossover between ports.
- Write-first/RAW: CPU writes 16'hFFFE to addr 106 at T, tst reads 106 at T+1 -> cpu_rdata = 16'hFFFE echo at T+RD_LAT; tst_rdata = 16'hFFFE.
- Boundary: ADDR_W=8, write 16'h00F4 to addr 255, read 255 and addr 0 -> 16'h00F4 and prior contents of 0 respectively, no aliasing.
- Reset mid-read: grant CPU read at T, assert rst_n low at T+0.5 cycle (RD_LAT=2), release after 2 cycles -> no cpu_rvalid ever; outputs 0; addr 255 still reads 16'h00F4.

Source files
------------

// File: rtl/shared_mem_arbiter.sv
// Single-bank shared memory for a CPU port and a test/loader port. The test port has fixed
// priority, but a CPU stalled for MAX_STALL consecutive cycles is granted on the next one.
module shared_mem_arbiter #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int RD_LAT    = 1,
    parameter int MAX_STALL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              tst_req,
    input  logic              tst_we,
    input  logic [ADDR_W-1:0] tst_addr,
    input  logic [DATA_W-1:0] tst_wdata,
    output logic              tst_ready,
    output logic [DATA_W-1:0] tst_rdata,
    output logic              tst_rvalid
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [3:0]        stall_cnt_q;

    logic              cpu_grant;
    logic              tst_grant;
    logic              acc_en;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [DATA_W-1:0] acc_data;

    logic              fin_vld;
    logic              fin_cpu;
    logic [DATA_W-1:0] fin_data;

    always_comb begin
        cpu_grant = cpu_req && (!tst_req || (stall_cnt_q == 4'(MAX_STALL)));
        tst_grant = tst_req && !cpu_grant;
        cpu_stall = cpu_req && !cpu_grant;
        tst_ready = tst_grant;
        acc_en    = cpu_grant || tst_grant;
        // CPU fields are only looked at when the CPU owns the cycle, so X there is harmless.
        acc_we    = cpu_grant ? cpu_we    : tst_we;
        acc_addr  = cpu_grant ? cpu_addr  : tst_addr;
        acc_wdata = cpu_grant ? cpu_wdata : tst_wdata;
        acc_data  = acc_we ? acc_wdata : mem[acc_addr];
    end

    // Memory array deliberately has no reset.
    always_ff @(posedge clk) begin
        if (acc_en && acc_we) begin
            mem[acc_addr] <= acc_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 4'd0;
        end else if (cpu_req && cpu_stall) begin
            if (stall_cnt_q != 4'(MAX_STALL)) begin
                stall_cnt_q <= stall_cnt_q + 4'd1;
            end
        end else begin
            stall_cnt_q <= 4'd0;
        end
    end

    if (RD_LAT == 1) begin : g_lat1
        assign fin_vld  = acc_en;
        assign fin_cpu  = cpu_grant;
        assign fin_data = acc_data;
    end else if (RD_LAT == 2) begin : g_lat2
        logic              vld_q;
        logic              cpu_q;
        logic [DATA_W-1:0] data_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q  <= 1'b0;
                cpu_q  <= 1'b0;
                data_q <= '0;
            end else begin
                vld_q <= acc_en;
                cpu_q <= cpu_grant;
                if (acc_en) begin
                    data_q <= acc_data;
                end
            end
        end

        assign fin_vld  = vld_q;
        assign fin_cpu  = cpu_q;
        assign fin_data = data_q;
    end else begin : g_bad_lat
        $error("shared_mem_arbiter: RD_LAT must be 1 or 2");
    end

    // Per-port output registers; rdata holds between valid pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rvalid <= 1'b0;
            tst_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            tst_rdata  <= '0;
        end else begin
            cpu_rvalid <= fin_vld && fin_cpu;
            tst_rvalid <= fin_vld && !fin_cpu;
            if (fin_vld && fin_cpu) begin
                cpu_rdata <= fin_data;
            end
            if (fin_vld && !fin_cpu) begin
                tst_rdata <= fin_data;
            end
        end
    end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench: one RD_LAT=1 and one RD_LAT=2 instance share stimulus, each checked
// against hand-computed expectations for its own latency.
module tb_shared_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [7:0]  cpu_addr = 8'd0;
    logic [15:0] cpu_wdata = 16'd0;
    logic        tst_req = 1'b0;
    logic        tst_we = 1'b0;
    logic [7:0]  tst_addr = 8'd0;
    logic [15:0] tst_wdata = 16'd0;

    logic        c1_stall, c1_rvalid, t1_ready, t1_rvalid;
    logic [15:0] c1_rdata, t1_rdata;
    logic        c2_stall, c2_rvalid, t2_ready, t2_rvalid;
    logic [15:0] c2_rdata, t2_rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shared_mem_arbiter #(.DATA_W(16), .ADDR_W(8), .RD_LAT(1), .MAX_STALL(4)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(c1_stall), .cpu_rdata(c1_rdata), .cpu_rvalid(c1_rvalid),
        .tst_req(tst_req), .tst_we(tst_we), .tst_addr(tst_addr), .tst_wdata(tst_wdata),
        .tst_ready(t1_ready), .tst_rdata(t1_rdata), .tst_rvalid(t1_rvalid)
    );

    shared_mem_arbiter #(.DATA_W(16), .ADDR_W(8), .RD_LAT(2), .MAX_STALL(4)) u_lat2 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(c2_stall), .cpu_rdata(c2_rdata), .cpu_rvalid(c2_rvalid),
        .tst_req(tst_req), .tst_we(tst_we), .tst_addr(tst_addr), .tst_wdata(tst_wdata),
        .tst_ready(t2_ready), .tst_rdata(t2_rdata), .tst_rvalid(t2_rvalid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Leaves the bench 1 time unit after a rising edge, ready to drive the next cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_drive(input logic req, input logic we, input logic [7:0] a,
                             input logic [15:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic tst_drive(input logic req, input logic we, input logic [7:0] a,
                             input logic [15:0] d);
        tst_req = req; tst_we = we; tst_addr = a; tst_wdata = d;
    endtask

    logic [15:0] vals [3];
    int c1_cnt, c2_cnt, t1_cnt, t2_cnt, bad;

    initial begin
        vals[0] = 16'h0232; vals[1] = 16'h0164; vals[2] = 16'h0333;

        // Reset state
        tick(); tick();
        check("rst_c1_rvalid", 32'(c1_rvalid), 0);
        check("rst_c2_rdata", 32'(c2_rdata), 0);
        check("rst_t1_rvalid", 32'(t1_rvalid), 0);
        check("rst_t2_rdata", 32'(t2_rdata), 0);
        rst_n = 1'b1;
        tick();

        // Test port writes 50, CPU reads it back
        tst_drive(1, 1, 8'd50, 16'h0001); #1;
        check("wr50_ready", 32'(t1_ready), 1);
        tick();
        tst_drive(0, 0, 8'd0, 16'h0); cpu_drive(1, 0, 8'd50, 16'h0); #1;
        check("rd50_stall", 32'(c1_stall), 0);
        check("wr50_echo1_v", 32'(t1_rvalid), 1);
        check("wr50_echo1_d", 32'(t1_rdata), 32'h0001);
        tick();
        cpu_drive(0, 0, 8'd0, 16'h0); #1;
        check("rd50_l1_v", 32'(c1_rvalid), 1);
        check("rd50_l1_d", 32'(c1_rdata), 32'h0001);
        check("rd50_l2_early", 32'(c2_rvalid), 0);
        check("wr50_echo2_v", 32'(t2_rvalid), 1);
        tick(); #1;
        check("rd50_l2_v", 32'(c2_rvalid), 1);
        check("rd50_l2_d", 32'(c2_rdata), 32'h0001);
        check("rd50_l1_pulse", 32'(c1_rvalid), 0);
        check("rd50_l1_hold", 32'(c1_rdata), 32'h0001);

        // Preload 0..2, then back-to-back CPU reads
        for (int i = 0; i < 3; i++) begin
            tick();
            tst_drive(1, 1, 8'(i), vals[i]);
        end
        tick();
        tst_drive(0, 0, 8'd0, 16'h0);
        tick(); tick();
        for (int i = 0; i < 6; i++) begin
            if (i < 3) cpu_drive(1, 0, 8'(i), 16'h0);
            else       cpu_drive(0, 0, 8'd0, 16'h0);
            #1;
            check($sformatf("b2b_l1_v%0d", i), 32'(c1_rvalid), 32'(i >= 1 && i <= 3));
            check($sformatf("b2b_l2_v%0d", i), 32'(c2_rvalid), 32'(i >= 2 && i <= 4));
            if (i >= 1 && i <= 3) check($sformatf("b2b_l1_d%0d", i), 32'(c1_rdata), 32'(vals[i-1]));
            if (i >= 2 && i <= 4) check($sformatf("b2b_l2_d%0d", i), 32'(c2_rdata), 32'(vals[i-2]));
            tick();
        end

        // Collision: both ports hold reads for 10 cycles
        c1_cnt = 0; c2_cnt = 0; t1_cnt = 0; t2_cnt = 0; bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 10) begin
                cpu_drive(1, 0, 8'd50, 16'h0);
                tst_drive(1, 0, 8'd0, 16'h0);
            end else begin
                cpu_drive(0, 0, 8'd0, 16'h0);
                tst_drive(0, 0, 8'd0, 16'h0);
            end
            #1;
            if (i < 10) begin
                check($sformatf("col_stall%0d", i), 32'(c1_stall), 32'(i % 5 != 4));
                check($sformatf("col_ready%0d", i), 32'(t2_ready), 32'(i % 5 != 4));
            end
            if (c1_rvalid) begin c1_cnt++; if (c1_rdata !== 16'h0001) bad++; end
            if (c2_rvalid) begin c2_cnt++; if (c2_rdata !== 16'h0001) bad++; end
            if (t1_rvalid) begin t1_cnt++; if (t1_rdata !== 16'h0232) bad++; end
            if (t2_rvalid) begin t2_cnt++; if (t2_rdata !== 16'h0232) bad++; end
            tick();
        end
        check("col_c1_pulses", 32'(c1_cnt), 2);
        check("col_c2_pulses", 32'(c2_cnt), 2);
        check("col_t1_pulses", 32'(t1_cnt), 8);
        check("col_t2_pulses", 32'(t2_cnt), 8);
        check("col_crossover", 32'(bad), 0);

        // Write-first echo and read-after-write across ports
        cpu_drive(1, 1, 8'd106, 16'hFFFE); #1;
        check("raw_stall", 32'(c1_stall), 0);
        tick();
        cpu_drive(0, 0, 8'd0, 16'h0); tst_drive(1, 0, 8'd106, 16'h0); #1;
        check("raw_echo1_v", 32'(c1_rvalid), 1);
        check("raw_echo1_d", 32'(c1_rdata), 32'hFFFE);
        tick();
        tst_drive(0, 0, 8'd0, 16'h0); #1;
        check("raw_t1_v", 32'(t1_rvalid), 1);
        check("raw_t1_d", 32'(t1_rdata), 32'hFFFE);
        check("raw_echo2_d", 32'(c2_rdata), 32'hFFFE);
        tick(); #1;
        check("raw_t2_v", 32'(t2_rvalid), 1);
        check("raw_t2_d", 32'(t2_rdata), 32'hFFFE);
        tick();

        // Top address, then address 0: no aliasing
        cpu_drive(1, 1, 8'd255, 16'h00F4);
        tick();
        cpu_drive(1, 0, 8'd255, 16'h0);
        tick();
        cpu_drive(1, 0, 8'd0, 16'h0); #1;
        check("bnd_l1_255", 32'(c1_rdata), 32'h00F4);
        tick();
        cpu_drive(0, 0, 8'd0, 16'h0); #1;
        check("bnd_l1_0", 32'(c1_rdata), 32'h0232);
        check("bnd_l2_255", 32'(c2_rdata), 32'h00F4);
        tick(); #1;
        check("bnd_l2_0", 32'(c2_rdata), 32'h0232);
        tick();

        // Reset lands while the RD_LAT=2 read is still in flight
        cpu_drive(1, 0, 8'd255, 16'h0);
        @(posedge clk);
        cpu_drive(0, 0, 8'd0, 16'h0);
        #5;
        rst_n = 1'b0;
        #1;
        check("mid_rst_c1_rdata", 32'(c1_rdata), 0);
        check("mid_rst_c2_rvalid", 32'(c2_rvalid), 0);
        tick(); tick();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (c1_rvalid || c2_rvalid || t1_rvalid || t2_rvalid) bad++;
            tick();
        end
        check("mid_rst_no_rvalid", 32'(bad), 0);
        check("mid_rst_c2_rdata", 32'(c2_rdata), 0);
        cpu_drive(1, 0, 8'd255, 16'h0);
        tick();
        cpu_drive(0, 0, 8'd0, 16'h0); #1;
        check("persist_l1", 32'(c1_rdata), 32'h00F4);
        tick(); #1;
        check("persist_l2", 32'(c2_rdata), 32'h00F4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
